uart_rx_ctrl: RTL
=================

UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 DEPTH, 16, RX FIFO entries; power of two, 4..256.
REQ-002 TOUT_CHARS, 4, idle character times before receive timeout; 1..15.
REQ-003 clk_i  in  1  clock, rising edge.
REQ-004 rstn_i  in  1  asynchronous active-low reset.
REQ-005 cfg_en_i  in  1  controller enable; low flushes the FIFO and clears the timeout logic.
REQ-006 cfg_div_i  in  16  baud divider; one bit period = cfg_div_i+1 cycles.
REQ-007 cfg_bits_i  in  2  data bits minus 5 (00=5 .. 11=8).
REQ-008 cfg_parity_en_i  in  1  parity bit present in frame.
REQ-009 cfg_thresh_i  in  AW+1  FIFO level threshold; AW=clog2(DEPTH).
REQ-010 cfg_ie_i  in  3  irq enables, bit0 threshold, bit1 timeout, bit2 error.
REQ-011 rx_data_i  in  8  received character from the receiver.
REQ-012 rx_valid_i  in  1  character valid.
REQ-013 rx_ready_o  out  1  character accepted; equals cfg_en_i, never back-pressures.
REQ-014 rx_busy_i  in  1  receiver mid-frame.
REQ-015 rx_err_i  in  1  receiver parity error level.
REQ-016 err_clr_o  out  1  one-cycle clear pulse to the receiver error.
REQ-017 pop_i  in  1  read strobe; removes the head entry.
REQ-018 rd_data_o  out  8  FIFO head, show-ahead; 0 when empty.
REQ-019 cnt_o  out  AW+1  FIFO occupancy.
REQ-020 stat_o  out  3  sticky flags: bit0 overrun, bit1 parity error, bit2 timeout.
REQ-021 stat_clr_i  in  3  write-1-to-clear, per stat_o bit.
REQ-022 irq_o  out  1  registered interrupt.

Function
REQ-023 rx_valid_i & rx_ready_o & cnt<DEPTH SHALL write rx_data_i at wptr the same cycle; cnt_o updates next cycle.
REQ-024 Push while full SHALL drop the data and set stat_o[0]; FIFO contents are unchanged.
REQ-025 pop_i & cnt>0 SHALL advance rptr; pop_i while empty SHALL be ignored with no flag.
REQ-026 Push and pop in the same cycle while full SHALL accept both; cnt is unchanged and no overrun is raised.
REQ-027 Push and pop in the same cycle while empty SHALL accept the push only.
REQ-028 Pointers SHALL be AW bits and wrap modulo DEPTH; cnt SHALL saturate at 0 and DEPTH.
REQ-029 Character length SHALL be 7 + cfg_bits_i + cfg_parity_en_i bit periods (range 7..11).
REQ-030 The timeout FSM SHALL have states T_IDLE, T_COUNT and T_EXPIRED.
REQ-031 T_IDLE→T_COUNT when cnt>0 & cfg_en_i; any→T_IDLE when cnt=0 or cfg_en_i low.
REQ-032 In T_COUNT, the bit-period and bit counters SHALL restart on push, on pop, or while rx_busy_i is high.
REQ-033 T_COUNT→T_EXPIRED after TOUT_CHARS×char-length bit periods; entry sets stat_o[2] for one cycle only.
REQ-034 T_EXPIRED→T_COUNT on push or pop.
REQ-035 A rising edge of rx_err_i SHALL set stat_o[1].
REQ-036 stat_clr_i[1] SHALL also pulse err_clr_o for one cycle.
REQ-037 Set and clear of a stat_o bit in the same cycle SHALL leave the bit set.
REQ-038 irq_o(next) = (ie0 & cnt≥cfg_thresh_i & cfg_thresh_i≠0) | (ie1 & stat2) | (ie2 & (stat0|stat1)).
REQ-039 cfg_en_i low SHALL reset the pointers and cnt within one cycle; stat_o SHALL be retained.

Reset
REQ-040 On rstn_i low: cnt_o=0, rd_data_o=0, stat_o=0, irq_o=0, err_clr_o=0, FSM=T_IDLE, pointers=0; FIFO storage SHALL NOT be reset.
REQ-041 Reset asserted mid-operation SHALL discard all FIFO content immediately.

Structure
REQ-042 Package uart_pkg SHALL hold the timeout FSM enum, the stat bit index constants and the char-length function.
REQ-043 Storage SHALL be a sub-module uart_rx_fifo (sync FIFO: push, pop, head, cnt); timeout and irq logic SHALL be in uart_rx_ctrl.

Verification
REQ-044 DEPTH=16: push 0x00..0x0F, then pop 16 → data in order, cnt 16→0, rd_data_o=0 after.
REQ-045 Full FIFO, push 0xAA → stat_o=001, head unchanged; same-cycle push and pop while full → cnt stays 16, no overrun.
REQ-046 div=3, 8N1, TOUT_CHARS=4, one character pushed then idle → stat_o[2] set 160 cycles (±1) after the push; a pop restarts the count.
REQ-047 thresh=8, ie=001: push 7 → irq_o=0; 8th push → irq_o=1 one cycle after cnt_o=8.
REQ-048 rx_err_i pulse → stat_o[1]=1; stat_clr_i=010 → err_clr_o one-cycle pulse and stat_o[1]=0; simultaneous set and clear keeps the bit set.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive controller.
// Holds the timeout FSM encoding, the stat bit positions and the character-length helper.
package uart_pkg;

    typedef enum logic [1:0] {
        T_IDLE,
        T_COUNT,
        T_EXPIRED
    } tout_state_e;

    localparam int STAT_OVR  = 0;
    localparam int STAT_PAR  = 1;
    localparam int STAT_TOUT = 2;

    // Bit periods per character: start + 5..8 data + optional parity + stop.
    function automatic logic [3:0] char_len(input logic [1:0] bits, input logic parity_en);
        return 4'd7 + {2'b00, bits} + {3'b000, parity_en};
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous show-ahead byte FIFO; the head reads as zero when empty.
// A push while full is dropped and flagged on overrun unless a pop frees a slot in the same cycle.
module uart_rx_fifo #(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rstn_i,
    input  logic          flush,
    input  logic          push,
    input  logic [7:0]    push_data,
    input  logic          pop,
    output logic [7:0]    head,
    output logic [AW:0]   cnt,
    output logic          overrun
);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   cnt_q;
    logic          full;
    logic          do_push;
    logic          do_pop;

    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~flush & (cnt_q != '0);
    assign do_push = push & ~flush & (~full | do_pop);
    assign overrun = push & ~flush & ~do_push;

    assign head = (cnt_q != '0) ? mem[rptr] : 8'h00;
    assign cnt  = cnt_q;

    // Storage carries no reset; occupancy alone decides what is visible.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wptr] <= push_data;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wptr  <= '0;
            rptr  <= '0;
            cnt_q <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: buffers received characters, tracks an idle-line timeout,
// keeps sticky status flags and drives a registered interrupt. Never back-pressures the receiver.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter  int DEPTH      = 16,
    parameter  int TOUT_CHARS = 4,
    localparam int AW         = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rstn_i,
    input  logic          cfg_en_i,
    input  logic [15:0]   cfg_div_i,
    input  logic [1:0]    cfg_bits_i,
    input  logic          cfg_parity_en_i,
    input  logic [AW:0]   cfg_thresh_i,
    input  logic [2:0]    cfg_ie_i,
    input  logic [7:0]    rx_data_i,
    input  logic          rx_valid_i,
    output logic          rx_ready_o,
    input  logic          rx_busy_i,
    input  logic          rx_err_i,
    output logic          err_clr_o,
    input  logic          pop_i,
    output logic [7:0]    rd_data_o,
    output logic [AW:0]   cnt_o,
    output logic [2:0]    stat_o,
    input  logic [2:0]    stat_clr_i,
    output logic          irq_o
);

    tout_state_e state_q;
    tout_state_e state_d;

    logic [AW:0]  cnt;
    logic         overrun;
    logic         push_evt;
    logic         pop_evt;
    logic         restart;
    logic         tout_fire;
    logic         tout_set;
    logic [7:0]   tout_bits;
    logic [15:0]  cyc_q;
    logic [7:0]   bits_q;
    logic         err_q;
    logic [2:0]   stat_q;
    logic [2:0]   stat_set;
    logic         err_clr_q;
    logic         irq_q;

    assign rx_ready_o = cfg_en_i;
    assign push_evt   = rx_valid_i & cfg_en_i;
    assign pop_evt    = pop_i & cfg_en_i & (cnt != '0);
    assign restart    = push_evt | pop_evt | rx_busy_i;

    uart_rx_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk_i     (clk_i),
        .rstn_i    (rstn_i),
        .flush     (~cfg_en_i),
        .push      (push_evt),
        .push_data (rx_data_i),
        .pop       (pop_i),
        .head      (rd_data_o),
        .cnt       (cnt),
        .overrun   (overrun)
    );

    assign cnt_o = cnt;

    // Total idle bit periods before the line is declared quiet.
    assign tout_bits = 8'(TOUT_CHARS) * {4'b0000, char_len(cfg_bits_i, cfg_parity_en_i)};
    assign tout_fire = (state_q == T_COUNT) & ~restart
                     & (cyc_q == cfg_div_i) & (bits_q == tout_bits - 8'd1);

    // Counters run whenever data is waiting, so the first idle cycle after a push is counted.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cyc_q  <= '0;
            bits_q <= '0;
        end else if (!cfg_en_i || cnt == '0 || restart || state_q == T_EXPIRED) begin
            cyc_q  <= '0;
            bits_q <= '0;
        end else if (cyc_q == cfg_div_i) begin
            cyc_q  <= '0;
            bits_q <= bits_q + 8'd1;
        end else begin
            cyc_q  <= cyc_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= T_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        tout_set = 1'b0;
        case (state_q)
            T_IDLE:    state_d = T_COUNT;
            T_COUNT:   if (tout_fire) state_d = T_EXPIRED;
            T_EXPIRED: if (push_evt || pop_evt) state_d = T_COUNT;
            default:   state_d = T_IDLE;
        endcase
        if (!cfg_en_i || cnt == '0) begin
            state_d = T_IDLE;
        end
        tout_set = (state_q == T_COUNT) && (state_d == T_EXPIRED);
    end

    always_comb begin
        stat_set            = '0;
        stat_set[STAT_OVR]  = overrun;
        stat_set[STAT_PAR]  = rx_err_i & ~err_q;
        stat_set[STAT_TOUT] = tout_set;
    end

    // Set wins over a same-cycle clear so no event is lost.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            err_q     <= 1'b0;
            stat_q    <= '0;
            err_clr_q <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            err_q     <= rx_err_i;
            stat_q    <= (stat_q & ~stat_clr_i) | stat_set;
            err_clr_q <= stat_clr_i[STAT_PAR];
            irq_q     <= (cfg_ie_i[0] & (cnt >= cfg_thresh_i) & (cfg_thresh_i != '0))
                       | (cfg_ie_i[1] & stat_q[STAT_TOUT])
                       | (cfg_ie_i[2] & (stat_q[STAT_OVR] | stat_q[STAT_PAR]));
        end
    end

    assign stat_o    = stat_q;
    assign err_clr_o = err_clr_q;
    assign irq_o     = irq_q;

endmodule
